// File: rtl/seven_seg_pkg.sv
// Shared 7-segment constants: GFEDCBA bit positions, hex glyph table (active-high)
// and the blank pattern, common to the display encoder and the capture block.
package seven_seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    logic [6:0] glyph_s;
    case (nibble)
      4'h0: glyph_s = SEG_0;
      4'h1: glyph_s = SEG_1;
      4'h2: glyph_s = SEG_2;
      4'h3: glyph_s = SEG_3;
      4'h4: glyph_s = SEG_4;
      4'h5: glyph_s = SEG_5;
      4'h6: glyph_s = SEG_6;
      4'h7: glyph_s = SEG_7;
      4'h8: glyph_s = SEG_8;
      4'h9: glyph_s = SEG_9;
      4'hA: glyph_s = SEG_HEX_A;
      4'hB: glyph_s = SEG_HEX_B;
      4'hC: glyph_s = SEG_HEX_C;
      4'hD: glyph_s = SEG_HEX_D;
      4'hE: glyph_s = SEG_HEX_E;
      default: glyph_s = SEG_HEX_F;
    endcase
    return glyph_s;
  endfunction

endpackage

// File: rtl/seven_segment_capture_if.sv
// Display-bus and result signals of the 7-segment capture block.
// SEVEN_SEG_CAPTURE_DP_EN adds the decimal-point input and per-digit DP result.
interface seven_segment_capture_if #(parameter int NUM_DIGITS = 4);

  logic [6:0]              i_Segment;
  logic [NUM_DIGITS-1:0]   i_Anode;
  logic [4*NUM_DIGITS-1:0] o_Value;
  logic [NUM_DIGITS-1:0]   o_Digit_Valid;
  logic                    o_Valid;
  logic                    o_Error;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
  logic                    i_Dp;
  logic [NUM_DIGITS-1:0]   o_Dp;

  modport master (output i_Segment, i_Anode, i_Dp,
                  input  o_Value, o_Digit_Valid, o_Valid, o_Error, o_Dp);
  modport slave  (input  i_Segment, i_Anode, i_Dp,
                  output o_Value, o_Digit_Valid, o_Valid, o_Error, o_Dp);
`else
  modport master (output i_Segment, i_Anode,
                  input  o_Value, o_Digit_Valid, o_Valid, o_Error);
  modport slave  (input  i_Segment, i_Anode,
                  output o_Value, o_Digit_Valid, o_Valid, o_Error);
`endif

endinterface

// File: rtl/seven_segment_pattern_decode.sv
// Combinational reverse lookup: active-high GFEDCBA pattern to hex nibble.
module seven_segment_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       is_hex,
  output logic       is_blank
);

  // Glyph match; anything outside the table is reported as non-hex
  always_comb begin
    nibble = 4'h0;
    is_hex = 1'b1;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_HEX_A: nibble = 4'hA;
      SEG_HEX_B: nibble = 4'hB;
      SEG_HEX_C: nibble = 4'hC;
      SEG_HEX_D: nibble = 4'hD;
      SEG_HEX_E: nibble = 4'hE;
      SEG_HEX_F: nibble = 4'hF;
      default:   is_hex = 1'b0;
    endcase
  end

  assign is_blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seven_segment_capture.sv
// Samples a multiplexed active-low 7-segment bus, commits each digit after a stable
// run and assembles the hex value. Optional DP capture: SEVEN_SEG_CAPTURE_DP_EN.
module seven_segment_capture
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
)(
  input logic                   i_Clk,
  input logic                   i_Rst,
  seven_segment_capture_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_CYCLES - 1);
`ifdef SEVEN_SEG_CAPTURE_DP_EN
  localparam int SW = NUM_DIGITS + 8;
`else
  localparam int SW = NUM_DIGITS + 7;
`endif

  logic [SW-1:0]           raw_s, sync_r, sample_r, prev_r;
  logic [NUM_DIGITS-1:0]   sel_s;
  logic [6:0]              pattern_s;
  logic [3:0]              nibble_s;
  logic                    is_hex_s, is_blank_s, stable_s, commit_s;
  logic [CW-1:0]           cnt_r;
  logic                    committed_r;
  logic [4*NUM_DIGITS-1:0] value_r, value_next_s;
  logic [NUM_DIGITS-1:0]   digit_valid_r, digit_valid_next_s;
  logic                    valid_r, error_r;

`ifdef SEVEN_SEG_CAPTURE_DP_EN
  logic [NUM_DIGITS-1:0]   dp_r, dp_next_s;
  assign raw_s = {bus.i_Dp, bus.i_Segment, bus.i_Anode};
`else
  assign raw_s = {bus.i_Segment, bus.i_Anode};
`endif

  // Two-flop synchronizer followed by the previous-sample register
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_r   <= '0;
      sample_r <= '0;
      prev_r   <= '0;
    end else begin
      sync_r   <= raw_s;
      sample_r <= sync_r;
      prev_r   <= sample_r;
    end
  end

  assign sel_s     = ~sample_r[NUM_DIGITS-1:0];
  assign pattern_s = ~sample_r[NUM_DIGITS +: 7];
  assign stable_s  = (sample_r == prev_r) && $onehot(sel_s);
  assign commit_s  = stable_s && (cnt_r == LAST_CNT) && !committed_r;

  seven_segment_pattern_decode u_decode (
    .pattern  (pattern_s),
    .nibble   (nibble_s),
    .is_hex   (is_hex_s),
    .is_blank (is_blank_s)
  );

  // Run counter saturates at the commit threshold; committed flag makes commit once-per-run
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt_r       <= '0;
      committed_r <= 1'b0;
    end else if (!stable_s) begin
      cnt_r       <= '0;
      committed_r <= 1'b0;
    end else begin
      cnt_r       <= (cnt_r == LAST_CNT) ? cnt_r : cnt_r + CW'(1);
      committed_r <= committed_r | commit_s;
    end
  end

  // Per-digit next state; sel_s is one-hot whenever commit_s is set
  always_comb begin
    value_next_s       = value_r;
    digit_valid_next_s = digit_valid_r;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    dp_next_s          = dp_r;
`endif
    for (int k = 0; k < NUM_DIGITS; k++) begin
      value_next_s[4*k +: 4] = (commit_s && sel_s[k] && is_hex_s) ? nibble_s : value_r[4*k +: 4];
      digit_valid_next_s[k]  = (commit_s && sel_s[k]) ? is_hex_s : digit_valid_r[k];
`ifdef SEVEN_SEG_CAPTURE_DP_EN
      dp_next_s[k]           = (commit_s && sel_s[k]) ? ~sample_r[NUM_DIGITS+7] : dp_r[k];
`endif
    end
  end

  // Registered results and one-cycle status pulses
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      value_r       <= '0;
      digit_valid_r <= '0;
      valid_r       <= 1'b0;
      error_r       <= 1'b0;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
      dp_r          <= '0;
`endif
    end else begin
      value_r       <= value_next_s;
      digit_valid_r <= digit_valid_next_s;
      valid_r       <= commit_s && is_hex_s && (&digit_valid_next_s);
      error_r       <= commit_s && !is_hex_s && !is_blank_s;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
      dp_r          <= dp_next_s;
`endif
    end
  end

  assign bus.o_Value       = value_r;
  assign bus.o_Digit_Valid = digit_valid_r;
  assign bus.o_Valid       = valid_r;
  assign bus.o_Error       = error_r;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
  assign bus.o_Dp          = dp_r;
`endif

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture (4 digits, 16-sample stability window).
module tb_seven_segment_capture;

  localparam int ND = 4;
  localparam int SC = 16;
  localparam logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int          cyc;
    logic [15:0] value;
    logic [3:0]  dv;
    logic        valid;
    logic        error;
    logic [3:0]  dp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q[$];

  // bench model state
  logic [11:0] last_drv;
  logic        fresh, committed;
  int          run_start;
  logic [15:0] m_value;
  logic [3:0]  m_dv, m_dp;
  logic [15:0] cur_value;
  logic [3:0]  cur_dv, cur_dp;

  seven_segment_capture_if #(.NUM_DIGITS(ND)) bus ();

  seven_segment_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    else n_pass++;
  endtask

  function automatic logic [25:0] observed();
    logic [3:0] dpv;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    dpv = bus.o_Dp;
`else
    dpv = 4'h0;
`endif
    return {bus.o_Value, bus.o_Digit_Valid, bus.o_Valid, bus.o_Error, dpv};
  endfunction

  // Drive one bus state from just after an edge for 'cycles' edges and predict any commit
  task automatic hold(input logic [6:0] pat, input logic [3:0] an, input logic dp_n, input int cycles);
    logic [11:0] drv;
    logic        hex, blank;
    logic [3:0]  nib;
    exp_t        e;
    drv = {dp_n, pat, an};
    bus.i_Segment = ~pat;
    bus.i_Anode   = an;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    bus.i_Dp      = dp_n;
`endif
    if (fresh || drv != last_drv) begin
      run_start = cyc + 1;
      committed = 1'b0;
    end
    fresh    = 1'b0;
    last_drv = drv;
    if ($onehot(~an) && !committed && (run_start + SC <= cyc + cycles)) begin
      committed = 1'b1;
      hex = 1'b0;
      nib = 4'h0;
      for (int i = 0; i < 16; i++) begin
        if (pat == GLY[i]) begin
          hex = 1'b1;
          nib = 4'(i);
        end
      end
      blank = (pat == 7'h00);
      for (int k = 0; k < ND; k++) begin
        if (!an[k]) begin
          if (hex) m_value[4*k +: 4] = nib;
          m_dv[k] = hex;
          m_dp[k] = ~dp_n;
        end
      end
      e.cyc   = run_start + 2 + SC;
      e.value = m_value;
      e.dv    = m_dv;
      e.valid = hex && (&m_dv);
      e.error = !hex && !blank;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
      e.dp    = m_dp;
`else
      e.dp    = 4'h0;
`endif
      q.push_back(e);
    end
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    m_value = 16'h0;
    m_dv = 4'h0;
    m_dp = 4'h0;
    q.delete();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    fresh = 1'b1;
  endtask

  // Scoreboard: every cycle the outputs must equal the last committed state with no pulses
  always @(negedge clk) begin
    if (rst) begin
      cur_value = 16'h0;
      cur_dv    = 4'h0;
      cur_dp    = 4'h0;
      check_val("reset", 64'(observed()), 64'd0);
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      cur_value = e.value;
      cur_dv    = e.dv;
      cur_dp    = e.dp;
      check_val("commit", 64'(observed()), 64'({e.value, e.dv, e.valid, e.error, e.dp}));
    end else begin
      check_val("idle", 64'(observed()), 64'({cur_value, cur_dv, 2'b00, cur_dp}));
    end
  end

  initial begin
    rst = 1'b1;
    bus.i_Segment = 7'h7F;
    bus.i_Anode   = 4'hF;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    bus.i_Dp      = 1'b1;
`endif
    fresh = 1'b1;
    committed = 1'b0;
    last_drv = 12'h0;
    run_start = 0;
    m_value = 16'h0;
    m_dv = 4'h0;
    m_dp = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(7'h00, 4'hF, 1'b1, 5);
    // glyphs 1..4 onto digits 0..3
    for (int k = 0; k < ND; k++) hold(GLY[k+1], 4'(~(4'b0001 << k)), 1'b1, 20);
    // one-cycle glitch inside a run
    hold(7'h5B, 4'hE, 1'b1, 10);
    hold(7'h5A, 4'hE, 1'b1, 1);
    hold(7'h5B, 4'hE, 1'b1, 20);
    // non-hex pattern, two anodes low, blank digit, restore
    hold(7'h49, 4'hB, 1'b1, 20);
    hold(7'h07, 4'b1100, 1'b1, 40);
    hold(7'h00, 4'hD, 1'b1, 20);
    hold(7'h77, 4'hD, 1'b1, 20);
    hold(7'h6D, 4'hB, 1'b1, 20);
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    hold(7'h7F, 4'h7, 1'b0, 20);
    hold(7'h7F, 4'h7, 1'b1, 20);
`endif
    // reset in the middle of a run, then a full new run
    hold(7'h00, 4'hF, 1'b1, 5);
    hold(7'h39, 4'hE, 1'b1, 12);
    do_reset(3);
    hold(7'h39, 4'hE, 1'b1, 20);
    hold(7'h00, 4'hF, 1'b1, 5);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    check_val("drain", 64'(q.size()), 64'd0);
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
